// File: rtl/id_decode_queue_pkg.sv
// Shared encodings for the decode queue: opcodes, control-field codes, the stored bundle
// and the immediate extract helpers.
package id_decode_queue_pkg;

    localparam int INSTR_W_C   = 32;
    localparam int WORD_W_C    = 32;
    localparam int ALU_OP_W_C  = 4;
    localparam int ALU_SRC_A_W = 2;
    localparam int ALU_SRC_B_W = 1;
    localparam int MEM_OP_W    = 4;
    localparam int DEST_SRC_W  = 2;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    typedef enum logic [ALU_OP_W_C-1:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    typedef enum logic [ALU_SRC_A_W-1:0] {
        SRC_A_XPR = 2'd0, SRC_A_PC = 2'd1, SRC_A_ZERO = 2'd2
    } alu_src_a_e;

    typedef enum logic [ALU_SRC_B_W-1:0] {
        SRC_B_XPR = 1'b0, SRC_B_IMM = 1'b1
    } alu_src_b_e;

    typedef enum logic [MEM_OP_W-1:0] {
        MEM_NOP, MEM_RD_BYTE, MEM_RD_HALF, MEM_RD_WORD, MEM_RD_BYTE_U,
        MEM_RD_HALF_U, MEM_WR_BYTE, MEM_WR_HALF, MEM_WR_WORD
    } mem_op_e;

    typedef enum logic [DEST_SRC_W-1:0] {
        DEST_NONE = 2'd0, DEST_ALU = 2'd1, DEST_MEM = 2'd2, DEST_PC4 = 2'd3
    } dest_src_e;

    typedef struct packed {
        alu_op_e    alu_op;
        alu_src_a_e a_src;
        alu_src_b_e b_src;
        mem_op_e    mem_op;
        dest_src_e  dest;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic       branch;
        logic       jump;
        logic       illegal;
    } dec_ctrl_t;

    function automatic logic [31:0] imm_i(input logic [31:0] i);
        return {{20{i[31]}}, i[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] i);
        return {{20{i[31]}}, i[31:25], i[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] i);
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] i);
        return {i[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    // alt selects SUB (funct3=0) or SRA (funct3=5); ignored for the other funct3 values
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/id_decode_queue_decoder_core.sv
// Combinational RV32I decoder: raw instruction -> control bundle plus sign-extended immediate.
module id_decoder_core
    import id_decode_queue_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_C,
    parameter int WORD_W  = WORD_W_C
) (
    input  logic [INSTR_W-1:0] instr,
    output logic [WORD_W-1:0]  imm,
    output dec_ctrl_t          ctrl
);

    logic [31:0] ins;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm32;
    logic        ok;

    assign ins    = instr[31:0];
    assign opcode = ins[6:0];
    assign f3     = ins[14:12];
    assign f7     = ins[31:25];

    always_comb begin
        ctrl        = '0;
        imm32       = '0;
        ok          = 1'b1;
        ctrl.alu_op = ALU_ADD;
        case (opcode)
            OPC_LUI: begin
                imm32      = imm_u(ins);
                ctrl.a_src = SRC_A_ZERO;
                ctrl.b_src = SRC_B_IMM;
                ctrl.dest  = DEST_ALU;
            end
            OPC_AUIPC: begin
                imm32      = imm_u(ins);
                ctrl.a_src = SRC_A_PC;
                ctrl.b_src = SRC_B_IMM;
                ctrl.dest  = DEST_ALU;
            end
            OPC_JAL: begin
                imm32      = imm_j(ins);
                ctrl.a_src = SRC_A_PC;
                ctrl.b_src = SRC_B_IMM;
                ctrl.dest  = DEST_PC4;
                ctrl.jump  = 1'b1;
            end
            OPC_JALR: begin
                imm32      = imm_i(ins);
                ctrl.b_src = SRC_B_IMM;
                ctrl.dest  = DEST_PC4;
                ctrl.jump  = 1'b1;
            end
            OPC_BRANCH: begin
                imm32       = imm_b(ins);
                ctrl.alu_op = ALU_SUB;
                ctrl.branch = 1'b1;
            end
            OPC_LOAD: begin
                imm32      = imm_i(ins);
                ctrl.b_src = SRC_B_IMM;
                ctrl.dest  = DEST_MEM;
                case (f3)
                    3'd0:    ctrl.mem_op = MEM_RD_BYTE;
                    3'd1:    ctrl.mem_op = MEM_RD_HALF;
                    3'd2:    ctrl.mem_op = MEM_RD_WORD;
                    3'd4:    ctrl.mem_op = MEM_RD_BYTE_U;
                    3'd5:    ctrl.mem_op = MEM_RD_HALF_U;
                    default: ok = 1'b0;
                endcase
            end
            OPC_STORE: begin
                imm32      = imm_s(ins);
                ctrl.b_src = SRC_B_IMM;
                case (f3)
                    3'd0:    ctrl.mem_op = MEM_WR_BYTE;
                    3'd1:    ctrl.mem_op = MEM_WR_HALF;
                    3'd2:    ctrl.mem_op = MEM_WR_WORD;
                    default: ok = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                // bit 30 of an I-imm only means SRAI for funct3=5; ADDI must ignore it
                imm32       = imm_i(ins);
                ctrl.alu_op = alu_from_f3(f3, (f3 == 3'd5) && ins[30]);
                ctrl.b_src  = SRC_B_IMM;
                ctrl.dest   = DEST_ALU;
            end
            OPC_OP: begin
                ok          = (f7 == 7'h00) ||
                              ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
                ctrl.alu_op = alu_from_f3(f3, f7[5]);
                ctrl.dest   = DEST_ALU;
            end
            default: ok = 1'b0;
        endcase

        if (!ok) begin
            ctrl         = '0;
            imm32        = '0;
            ctrl.illegal = 1'b1;
        end
        ctrl.rd     = ins[11:7];
        ctrl.rs1    = ins[19:15];
        ctrl.rs2    = ins[24:20];
        ctrl.funct3 = f3;
        if (ctrl.rd == 5'd0)
            ctrl.dest = DEST_NONE;
    end

    assign imm = WORD_W'($signed(imm32));

endmodule

// File: rtl/id_decode_queue.sv
// Decode stage: decodes fetched instructions on entry and buffers the bundles in a
// DEPTH-entry FIFO so EX back-pressure does not stall fetch.
module id_decode_queue
    import id_decode_queue_pkg::*;
#(
    parameter int INSTR_W  = INSTR_W_C,
    parameter int WORD_W   = WORD_W_C,
    parameter int ALU_OP_W = ALU_OP_W_C,
    parameter int DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [INSTR_W-1:0]        in_instr,
    input  logic [WORD_W-1:0]         in_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WORD_W-1:0]         out_pc,
    output logic [ALU_OP_W-1:0]       out_alu_op,
    output logic [WORD_W-1:0]         out_imm,
    output logic [ALU_SRC_A_W-1:0]    out_alu_a_src,
    output logic [ALU_SRC_B_W-1:0]    out_alu_b_src,
    output logic [MEM_OP_W-1:0]       out_mem_op,
    output logic [DEST_SRC_W-1:0]     out_dest_src,
    output logic [4:0]                out_rd,
    output logic [4:0]                out_rs1,
    output logic [4:0]                out_rs2,
    output logic                      out_branch,
    output logic [2:0]                out_funct3,
    output logic                      out_jump,
    output logic                      out_illegal,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    dec_ctrl_t         dec_ctrl;
    logic [WORD_W-1:0] dec_imm;

    id_decoder_core #(.INSTR_W(INSTR_W), .WORD_W(WORD_W)) u_core (
        .instr (in_instr),
        .imm   (dec_imm),
        .ctrl  (dec_ctrl)
    );

    dec_ctrl_t         ctrl_mem [DEPTH];
    logic [WORD_W-1:0] imm_mem  [DEPTH];
    logic [WORD_W-1:0] pc_mem   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              push, pop;

    assign in_ready  = (count < CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // storage needs no reset: nothing is visible until count says so
    always_ff @(posedge clk) begin
        if (push) begin
            ctrl_mem[wr_ptr] <= dec_ctrl;
            imm_mem[wr_ptr]  <= dec_imm;
            pc_mem[wr_ptr]   <= in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    dec_ctrl_t         head;
    logic [WORD_W-1:0] head_imm, head_pc;

    always_comb begin
        head     = '0;
        head_imm = '0;
        head_pc  = '0;
        if (out_valid) begin
            head     = ctrl_mem[rd_ptr];
            head_imm = imm_mem[rd_ptr];
            head_pc  = pc_mem[rd_ptr];
        end
    end

    assign out_pc        = head_pc;
    assign out_imm       = head_imm;
    assign out_alu_op    = ALU_OP_W'(head.alu_op);
    assign out_alu_a_src = head.a_src;
    assign out_alu_b_src = head.b_src;
    assign out_mem_op    = head.mem_op;
    assign out_dest_src  = head.dest;
    assign out_rd        = head.rd;
    assign out_rs1       = head.rs1;
    assign out_rs2       = head.rs2;
    assign out_branch    = head.branch;
    assign out_funct3    = head.funct3;
    assign out_jump      = head.jump;
    assign out_illegal   = head.illegal;

endmodule

// File: tb/tb_id_decode_queue.sv
// Scoreboard bench for id_decode_queue: directed cases then randomized traffic against
// an arithmetic reference decoder and a queue model.
module tb_id_decode_queue;
    import id_decode_queue_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [31:0] in_instr, in_pc, out_pc, out_imm;
    logic [3:0]  out_alu_op, out_mem_op;
    logic [1:0]  out_alu_a_src, out_dest_src;
    logic [0:0]  out_alu_b_src;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic        out_branch, out_jump, out_illegal;
    logic [2:0]  out_funct3, count;

    id_decode_queue #(.INSTR_W(32), .WORD_W(32), .ALU_OP_W(4), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_alu_op(out_alu_op), .out_imm(out_imm),
        .out_alu_a_src(out_alu_a_src), .out_alu_b_src(out_alu_b_src),
        .out_mem_op(out_mem_op), .out_dest_src(out_dest_src), .out_rd(out_rd),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_branch(out_branch),
        .out_funct3(out_funct3), .out_jump(out_jump), .out_illegal(out_illegal),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  alu_op;
        logic [31:0] imm;
        logic [1:0]  a_src;
        logic [0:0]  b_src;
        logic [3:0]  mem_op;
        logic [1:0]  dest;
        logic [4:0]  rd, rs1, rs2;
        logic        branch;
        logic [2:0]  funct3;
        logic        jump, illegal;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] pc_cnt = 32'h100;

    logic [3:0] alu_tab  [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    logic [3:0] load_tab [8] = '{MEM_RD_BYTE, MEM_RD_HALF, MEM_RD_WORD, MEM_NOP,
                                 MEM_RD_BYTE_U, MEM_RD_HALF_U, MEM_NOP, MEM_NOP};
    logic [3:0] store_tab[8] = '{MEM_WR_BYTE, MEM_WR_HALF, MEM_WR_WORD, MEM_NOP,
                                 MEM_NOP, MEM_NOP, MEM_NOP, MEM_NOP};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        int   f3, f7, v;
        bit   ok;
        e = '0;
        f3 = int'(ins[14:12]);
        f7 = int'(ins[31:25]);
        ok = 1;
        case (int'(ins[6:0]))
            'h37: begin e.imm = ins & 32'hFFFFF000; e.a_src = SRC_A_ZERO; e.b_src = SRC_B_IMM; e.dest = DEST_ALU; end
            'h17: begin e.imm = ins & 32'hFFFFF000; e.a_src = SRC_A_PC; e.b_src = SRC_B_IMM; e.dest = DEST_ALU; end
            'h6F: begin
                v = (ins[31] ? -(1 << 20) : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                    + int'(ins[30:21]) * 2;
                e.imm = 32'(v); e.a_src = SRC_A_PC; e.b_src = SRC_B_IMM; e.dest = DEST_PC4; e.jump = 1;
            end
            'h67: begin e.imm = 32'($signed(ins) >>> 20); e.b_src = SRC_B_IMM; e.dest = DEST_PC4; e.jump = 1; end
            'h63: begin
                v = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
                e.imm = 32'(v); e.alu_op = ALU_SUB; e.branch = 1;
            end
            'h03: begin
                e.imm = 32'($signed(ins) >>> 20); e.b_src = SRC_B_IMM; e.dest = DEST_MEM;
                e.mem_op = load_tab[f3]; ok = (e.mem_op != MEM_NOP);
            end
            'h23: begin
                v = int'($signed(ins) >>> 25) * 32 + int'(ins[11:7]);
                e.imm = 32'(v); e.b_src = SRC_B_IMM; e.mem_op = store_tab[f3]; ok = (f3 <= 2);
            end
            'h13: begin
                e.imm = 32'($signed(ins) >>> 20); e.b_src = SRC_B_IMM; e.dest = DEST_ALU;
                e.alu_op = (f3 == 5 && ins[30]) ? ALU_SRA : alu_tab[f3];
            end
            'h33: begin
                e.dest = DEST_ALU;
                ok = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5));
                if (f7 == 'h20 && f3 == 0)      e.alu_op = ALU_SUB;
                else if (f7 == 'h20 && f3 == 5) e.alu_op = ALU_SRA;
                else                            e.alu_op = alu_tab[f3];
            end
            default: ok = 0;
        endcase
        if (!ok) begin
            e = '0;
            e.illegal = 1;
        end
        e.pc = pc; e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.funct3 = ins[14:12];
        if (e.rd == 0) e.dest = DEST_NONE;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] opc;
        logic [6:0] f7;
        case ($urandom_range(0, 10))
            0: opc = 7'h37;  1: opc = 7'h17;  2: opc = 7'h6F;  3: opc = 7'h67;
            4: opc = 7'h63;  5: opc = 7'h03;  6: opc = 7'h23;  7: opc = 7'h13;
            8, 9: opc = 7'h33;
            default: opc = 7'($urandom);
        endcase
        case ($urandom_range(0, 2))
            0: f7 = 7'h00;  1: f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom_range(0, 31)), opc};
    endfunction

    // queue model: pushes the expected bundle when the stimulus is accepted
    bit do_push, do_pop;
    always @(posedge clk) begin
        if (!rst_n || flush) exp_q.delete();
        else begin
            do_push = in_valid && (exp_q.size() < DEPTH);
            do_pop  = out_ready && (exp_q.size() > 0);
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(ref_decode(in_instr, in_pc));
        end
    end

    // monitor: compares the presented head (or the all-zero idle bundle) every cycle
    exp_t mon_exp, mon_act;
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            mon_exp = (exp_q.size() != 0) ? exp_q[0] : '0;
            mon_act = '{pc: out_pc, alu_op: out_alu_op, imm: out_imm, a_src: out_alu_a_src,
                        b_src: out_alu_b_src, mem_op: out_mem_op, dest: out_dest_src,
                        rd: out_rd, rs1: out_rs1, rs2: out_rs2, branch: out_branch,
                        funct3: out_funct3, jump: out_jump, illegal: out_illegal};
            chk("count",     128'(count),     128'(exp_q.size()));
            chk("out_valid", 128'(out_valid), 128'(exp_q.size() != 0));
            chk("in_ready",  128'(in_ready),  128'(exp_q.size() < DEPTH));
            chk("head",      128'(mon_act),   128'(mon_exp));
        end
    end

    task automatic drive(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
        in_valid = v; in_instr = ins; in_pc = pc_cnt; out_ready = rdy; flush = fl;
        @(posedge clk);
        #1;
        pc_cnt += 32'd4;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 32'hFFB10093, 1'b0, 1'b0);
        drive(1'b1, 32'hFFB10093, 1'b0, 1'b0);
        @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_count",     128'(count),     128'(0));
        chk("rst_imm",       128'(out_imm),   128'(0));
        rst_n = 1'b1;

        drive(1'b1, 32'hFFB10093, 1'b0, 1'b0);          // addi x1,x2,-5
        @(negedge clk);
        chk("addi_imm", 128'(out_imm),       128'(32'hFFFFFFFB));
        chk("addi_op",  128'(out_alu_op),    128'(ALU_ADD));
        chk("addi_b",   128'(out_alu_b_src), 128'(SRC_B_IMM));
        chk("addi_rd",  128'({out_rd, out_rs1}), 128'({5'd1, 5'd2}));
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        drive(1'b1, 32'h0040A183, 1'b0, 1'b0);          // lw x3,4(x1)
        @(negedge clk);
        chk("lw_fields", 128'({out_mem_op, out_imm, out_dest_src}),
            128'({MEM_RD_WORD, 32'd4, DEST_MEM}));
        drive(1'b1, 32'h00512423, 1'b1, 1'b0);          // sw x5,8(x2) while lw pops
        @(negedge clk);
        chk("sw_fields", 128'({out_mem_op, out_imm, out_dest_src}),
            128'({MEM_WR_WORD, 32'd8, DEST_NONE}));
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        for (int i = 0; i < 5; i++) begin               // fill; fifth is refused
            drive(1'b1, {12'(i + 1), 5'd2, 3'd0, 5'd1, 7'h13}, 1'b0, 1'b0);
            if (i == 3) begin
                @(negedge clk);
                chk("full_count",    128'(count),    128'(4));
                chk("full_in_ready", 128'(in_ready), 128'(0));
            end
        end
        for (int i = 0; i < 5; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);

        drive(1'b1, 32'h00100093, 1'b0, 1'b0);
        drive(1'b1, 32'h00200093, 1'b0, 1'b0);
        drive(1'b1, 32'h00300093, 1'b1, 1'b0);          // push+pop at count 2
        @(negedge clk);
        chk("pushpop_count", 128'(count), 128'(2));
        drive(1'b1, 32'h00400093, 1'b0, 1'b1);          // flush drops the concurrent input
        @(negedge clk);
        chk("flush_count", 128'({count, out_valid}), 128'({3'd0, 1'b0}));
        for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);

        drive(1'b1, 32'h0000007F, 1'b0, 1'b0);
        @(negedge clk);
        chk("illegal_fields", 128'({out_illegal, out_mem_op, out_dest_src}),
            128'({1'b1, MEM_NOP, DEST_NONE}));
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) rst_n = 1'b0;
            if (n == 1501) rst_n = 1'b1;
            drive($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 40) == 0);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
